// File: rtl/gci_std_display_timing_gen_if.sv
// rtl/gci_std_display_timing_gen_if.sv - pixel read and display bus between the timing generator and its neighbours
// Purpose: bundles the VRAM read-FIFO handshake and the display output signals.
// Signals:
//   oRD_ENA, oRD_SYNC               read request / frame-realign pulse (timing gen -> read stage)
//   iRD_VALID, iRD_DATA_R/G/B       pixel returned one cycle after oRD_ENA (read stage -> timing gen)
//   oDISP_HSYNC/VSYNC/DE, oDISP_R/G/B display timing and pixel outputs
//   oUNDERFLOW                      sticky flag: a visible pixel arrived without valid data
// Modports: master = timing generator side, slave = read stage / display sink side.
interface gci_std_display_timing_gen_if;
  logic       oRD_ENA;
  logic       oRD_SYNC;
  logic       iRD_VALID;
  logic [7:0] iRD_DATA_R;
  logic [7:0] iRD_DATA_G;
  logic [7:0] iRD_DATA_B;
  logic       oDISP_HSYNC;
  logic       oDISP_VSYNC;
  logic       oDISP_DE;
  logic [7:0] oDISP_R;
  logic [7:0] oDISP_G;
  logic [7:0] oDISP_B;
  logic       oUNDERFLOW;

  modport master (
    output oRD_ENA, oRD_SYNC,
    input  iRD_VALID, iRD_DATA_R, iRD_DATA_G, iRD_DATA_B,
    output oDISP_HSYNC, oDISP_VSYNC, oDISP_DE, oDISP_R, oDISP_G, oDISP_B, oUNDERFLOW
  );

  modport slave (
    input  oRD_ENA, oRD_SYNC,
    output iRD_VALID, iRD_DATA_R, iRD_DATA_G, iRD_DATA_B,
    input  oDISP_HSYNC, oDISP_VSYNC, oDISP_DE, oDISP_R, oDISP_G, oDISP_B, oUNDERFLOW
  );
endinterface

// File: rtl/gci_std_display_timing_gen.sv
// rtl/gci_std_display_timing_gen.sv - raster timing generator with VRAM read request and pixel output pipeline
// Purpose: counts pixels/lines, requests visible pixels from the read FIFO, and emits
//          hsync/vsync/de/RGB aligned two clocks after the counter position.
// Ports:
//   iDISP_CLOCK  pixel clock, all logic on its rising edge
//   inRESET      asynchronous active-low reset
//   iRESET_SYNC  synchronous clear with the same effect as reset
//   iDISP_ENA    display run enable; sampled to start a frame and at frame end
//   disp         read handshake and display outputs (master modport)
module gci_std_display_timing_gen #(
  parameter int P_H_ACTIVE = 640,
  parameter int P_H_FRONT  = 16,
  parameter int P_H_SYNC   = 96,
  parameter int P_H_BACK   = 48,
  parameter int P_V_ACTIVE = 480,
  parameter int P_V_FRONT  = 10,
  parameter int P_V_SYNC   = 2,
  parameter int P_V_BACK   = 33,
  parameter int P_SYNC_POL = 0
) (
  input  logic                                iDISP_CLOCK,
  input  logic                                inRESET,
  input  logic                                iRESET_SYNC,
  input  logic                                iDISP_ENA,
  gci_std_display_timing_gen_if.master        disp
);
  localparam int H_TOTAL = P_H_ACTIVE + P_H_FRONT + P_H_SYNC + P_H_BACK;
  localparam int V_TOTAL = P_V_ACTIVE + P_V_FRONT + P_V_SYNC + P_V_BACK;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT      = H_W'(P_H_ACTIVE);
  localparam logic [V_W-1:0] V_ACT      = V_W'(P_V_ACTIVE);
  localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(P_H_ACTIVE + P_H_FRONT);
  localparam logic [H_W-1:0] H_SYNC_END = H_W'(P_H_ACTIVE + P_H_FRONT + P_H_SYNC - 1);
  localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(P_V_ACTIVE + P_V_FRONT);
  localparam logic [V_W-1:0] V_SYNC_END = V_W'(P_V_ACTIVE + P_V_FRONT + P_V_SYNC - 1);
  localparam logic           W_POL      = (P_SYNC_POL != 0);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [H_W-1:0]  r_h_cnt, w_h_cnt_nxt;
  logic [V_W-1:0]  r_v_cnt, w_v_cnt_nxt;
  logic            w_rd_sync;
  logic            w_rd_ena;
  logic            w_hs_raw;
  logic            w_vs_raw;
  logic            w_clear;

  logic            r_de_d1, r_de_d2;
  logic            r_hs_d1, r_hs_d2;
  logic            r_vs_d1, r_vs_d2;
  logic [23:0]     r_rgb;
  logic            r_underflow;

  // A synchronous clear overrides everything the block would do this cycle,
  // including a frame-end or start-of-run oRD_SYNC pulse.
  assign w_clear = iRESET_SYNC || !inRESET;

  always_ff @(posedge iDISP_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_state <= ST_IDLE;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (iRESET_SYNC) begin
      r_state <= ST_IDLE;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_h_cnt <= w_h_cnt_nxt;
      r_v_cnt <= w_v_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_h_cnt_nxt = r_h_cnt;
    w_v_cnt_nxt = r_v_cnt;
    w_rd_sync   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_h_cnt_nxt = '0;
        w_v_cnt_nxt = '0;
        if (iDISP_ENA) begin
          w_state_nxt = ST_RUN;
          w_rd_sync   = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_h_cnt == H_LAST) begin
          w_h_cnt_nxt = '0;
          if (r_v_cnt == V_LAST) begin
            // Enable is only honoured here so a frame is never cut short.
            w_v_cnt_nxt = '0;
            w_rd_sync   = 1'b1;
            if (!iDISP_ENA) w_state_nxt = ST_IDLE;
          end else begin
            w_v_cnt_nxt = r_v_cnt + 1'b1;
          end
        end else begin
          w_h_cnt_nxt = r_h_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_clear) w_rd_sync = 1'b0;
  end

  assign w_rd_ena = (r_state == ST_RUN) && (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT) && !iRESET_SYNC;
  assign w_hs_raw = (r_state == ST_RUN) && (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt <= H_SYNC_END);
  assign w_vs_raw = (r_state == ST_RUN) && (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt <= V_SYNC_END);

  // Stage 1 lines up with the returning pixel (iRD_VALID is one cycle after
  // oRD_ENA); stage 2 and the RGB register then present both together.
  always_ff @(posedge iDISP_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_de_d1     <= 1'b0;
      r_de_d2     <= 1'b0;
      r_hs_d1     <= 1'b0;
      r_hs_d2     <= 1'b0;
      r_vs_d1     <= 1'b0;
      r_vs_d2     <= 1'b0;
      r_rgb       <= '0;
      r_underflow <= 1'b0;
    end else if (iRESET_SYNC) begin
      r_de_d1     <= 1'b0;
      r_de_d2     <= 1'b0;
      r_hs_d1     <= 1'b0;
      r_hs_d2     <= 1'b0;
      r_vs_d1     <= 1'b0;
      r_vs_d2     <= 1'b0;
      r_rgb       <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_de_d1 <= w_rd_ena;
      r_de_d2 <= r_de_d1;
      r_hs_d1 <= w_hs_raw;
      r_hs_d2 <= r_hs_d1;
      r_vs_d1 <= w_vs_raw;
      r_vs_d2 <= r_vs_d1;
      r_rgb   <= (r_de_d1 && disp.iRD_VALID) ?
                 {disp.iRD_DATA_R, disp.iRD_DATA_G, disp.iRD_DATA_B} : 24'd0;
      if (r_de_d1 && !disp.iRD_VALID) r_underflow <= 1'b1;
    end
  end

  assign disp.oRD_ENA     = w_rd_ena;
  assign disp.oRD_SYNC    = w_rd_sync;
  assign disp.oDISP_HSYNC = r_hs_d2 ? W_POL : ~W_POL;
  assign disp.oDISP_VSYNC = r_vs_d2 ? W_POL : ~W_POL;
  assign disp.oDISP_DE    = r_de_d2;
  assign disp.oDISP_R     = r_rgb[23:16];
  assign disp.oDISP_G     = r_rgb[15:8];
  assign disp.oDISP_B     = r_rgb[7:0];
  assign disp.oUNDERFLOW  = r_underflow;
endmodule
